// File: rtl/hwpe_ctrl_regfile_arb.sv
// -----------------------------------------------------------------------------
// hwpe_ctrl_regfile_arb
//
// Two-requester round-robin arbiter in front of a single-port register file.
// Requester 0 is the configuration bus and requester 1 is the engine. A granted
// request is forwarded to the regfile in the same cycle. One cycle later the
// owner gets an r_valid pulse. For a read, r_data carries the regfile read
// data. For a write, r_data is zero.
//
// A flush request clears the whole regfile through a short sequence:
//    ARB    -> FLUSH  : rf_clear is high for one cycle
//    FLUSH  -> SETTLE : one quiet cycle, flush_ack is high
//    SETTLE -> ARB
// No grants are issued outside ARB, and none while flush_req is high.
//
// Optional feature (macro HWPE_CTRL_REGFILE_ARB_RAW_STALL_EN):
//    In the cycle after a granted write to address A, a read to A is held
//    back. The other requester may be granted in that cycle instead.
//
// Ports
//    clk              sole clock, rising edge
//    clear            synchronous active-high reset
//    req/gnt          per-requester request / grant (grant one-hot or zero)
//    wen              per-requester write (1) / read (0)
//    addr/wdata/be    per-requester packed address, write data, byte enables
//    r_valid/r_data   per-requester response strobe, shared response data
//    flush_req/ack    regfile flush request / one-cycle completion pulse
//    rf_*             regfile-side read, write and clear controls
//    rf_read_data     regfile read data, valid one cycle after rf_read_enable
// -----------------------------------------------------------------------------
module hwpe_ctrl_regfile_arb #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_BYTE   = DATA_WIDTH / 8
) (
   input  logic                      clk,
   input  logic                      clear,
   input  logic [1:0]                req,
   output logic [1:0]                gnt,
   input  logic [1:0]                wen,
   input  logic [2*ADDR_WIDTH-1:0]   addr,
   input  logic [2*DATA_WIDTH-1:0]   wdata,
   input  logic [2*NUM_BYTE-1:0]     be,
   output logic [1:0]                r_valid,
   output logic [DATA_WIDTH-1:0]     r_data,
   input  logic                      flush_req,
   output logic                      flush_ack,
   output logic                      rf_read_enable,
   output logic [ADDR_WIDTH-1:0]     rf_read_addr,
   output logic                      rf_write_enable,
   output logic [ADDR_WIDTH-1:0]     rf_write_addr,
   output logic [DATA_WIDTH-1:0]     rf_write_data,
   output logic [NUM_BYTE-1:0]       rf_write_be,
   output logic                      rf_clear,
   input  logic [DATA_WIDTH-1:0]     rf_read_data
);

   typedef enum logic [1:0] {
      ARB    = 2'd0,
      FLUSH  = 2'd1,
      SETTLE = 2'd2
   } state_t;

   state_t          state_reg, state_next;
   logic            prio_reg, prio_next;            // requester favoured on a tie
   logic [1:0]      resp_valid_reg, resp_valid_next;
   logic            resp_read_reg, resp_read_next;

   logic [ADDR_WIDTH-1:0] addr_arr  [2];
   logic [DATA_WIDTH-1:0] wdata_arr [2];
   logic [NUM_BYTE-1:0]   be_arr    [2];
   logic [1:0]            eligible;

   logic            arb_open;
   logic            grant_any;
   logic            winner;
   logic            win_wen;

   // Split the packed per-requester buses into one entry per requester.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
         assign addr_arr[gi]  = addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign wdata_arr[gi] = wdata[gi*DATA_WIDTH +: DATA_WIDTH];
         assign be_arr[gi]    = be[gi*NUM_BYTE +: NUM_BYTE];
      end
   endgenerate

`ifdef HWPE_CTRL_REGFILE_ARB_RAW_STALL_EN
   // Remember the address of the write granted in the previous cycle.
   logic                  last_wr_valid_reg, last_wr_valid_next;
   logic [ADDR_WIDTH-1:0] last_wr_addr_reg, last_wr_addr_next;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_hazard
         assign eligible[gi] = req[gi] &
                               ~(~wen[gi] & last_wr_valid_reg &
                                 (addr_arr[gi] == last_wr_addr_reg));
      end
   endgenerate

   assign last_wr_valid_next = grant_any & win_wen;
   assign last_wr_addr_next  = addr_arr[winner];

   always_ff @(posedge clk) begin
      if (clear) begin
         last_wr_valid_reg <= 1'b0;
         last_wr_addr_reg  <= '0;
      end else begin
         last_wr_valid_reg <= last_wr_valid_next;
         last_wr_addr_reg  <= last_wr_addr_next;
      end
   end
`else
   assign eligible = req;
`endif

   // Arbitration runs only in ARB. It is suppressed during reset, and a flush
   // request takes precedence over any request in the same cycle.
   assign arb_open = (state_reg == ARB) & ~clear & ~flush_req;

   always_comb begin
      grant_any = 1'b0;
      winner    = 1'b0;
      if (arb_open) begin
         if (eligible[prio_reg]) begin
            grant_any = 1'b1;
            winner    = prio_reg;
         end else if (eligible[~prio_reg]) begin
            grant_any = 1'b1;
            winner    = ~prio_reg;
         end
      end
   end

   assign win_wen = wen[winner];

   // After a grant, the other requester is favoured next.
   assign prio_next       = grant_any ? ~winner : prio_reg;
   assign resp_valid_next = gnt;
   assign resp_read_next  = rf_read_enable;

   // State and bookkeeping registers.
   always_ff @(posedge clk) begin
      if (clear) begin
         state_reg      <= ARB;
         prio_reg       <= 1'b0;
         resp_valid_reg <= 2'b00;
         resp_read_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         prio_reg       <= prio_next;
         resp_valid_reg <= resp_valid_next;
         resp_read_reg  <= resp_read_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ARB:     if (flush_req) state_next = FLUSH;
         FLUSH:   state_next = SETTLE;
         SETTLE:  state_next = ARB;
         default: state_next = ARB;
      endcase
   end

   // Output logic.
   always_comb begin
      gnt             = 2'b00;
      rf_read_enable  = 1'b0;
      rf_write_enable = 1'b0;
      if (grant_any) begin
         gnt             = winner ? 2'b10 : 2'b01;
         rf_read_enable  = ~win_wen;
         rf_write_enable = win_wen;
      end
      rf_read_addr  = addr_arr[winner];
      rf_write_addr = addr_arr[winner];
      rf_write_data = wdata_arr[winner];
      rf_write_be   = be_arr[winner];
      rf_clear      = (state_reg == FLUSH) & ~clear;
      flush_ack     = (state_reg == SETTLE) & ~clear;
   end

   // A response that would land during a reset cycle is dropped.
   assign r_valid = resp_valid_reg & {2{~clear}};
   assign r_data  = (resp_read_reg & (|r_valid)) ? rf_read_data : '0;

endmodule

// File: tb/tb_hwpe_ctrl_regfile_arb.sv
// -----------------------------------------------------------------------------
// tb_hwpe_ctrl_regfile_arb
//
// Testbench for hwpe_ctrl_regfile_arb with the default configuration. The
// bench provides a small regfile behind the rf_* ports. A reference model
// predicts every cycle's grant, regfile controls, flush handshake and
// response. Directed scenarios come first, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_hwpe_ctrl_regfile_arb;

   logic        clk;
   logic        clear;
   logic [1:0]  req;
   logic [1:0]  gnt;
   logic [1:0]  wen;
   logic [9:0]  addr;
   logic [63:0] wdata;
   logic [7:0]  be;
   logic [1:0]  r_valid;
   logic [31:0] r_data;
   logic        flush_req;
   logic        flush_ack;
   logic        rf_read_enable;
   logic [4:0]  rf_read_addr;
   logic        rf_write_enable;
   logic [4:0]  rf_write_addr;
   logic [31:0] rf_write_data;
   logic [3:0]  rf_write_be;
   logic        rf_clear;
   logic [31:0] rf_read_data;

   hwpe_ctrl_regfile_arb dut (
      .clk             (clk),
      .clear           (clear),
      .req             (req),
      .gnt             (gnt),
      .wen             (wen),
      .addr            (addr),
      .wdata           (wdata),
      .be              (be),
      .r_valid         (r_valid),
      .r_data          (r_data),
      .flush_req       (flush_req),
      .flush_ack       (flush_ack),
      .rf_read_enable  (rf_read_enable),
      .rf_read_addr    (rf_read_addr),
      .rf_write_enable (rf_write_enable),
      .rf_write_addr   (rf_write_addr),
      .rf_write_data   (rf_write_data),
      .rf_write_be     (rf_write_be),
      .rf_clear        (rf_clear),
      .rf_read_data    (rf_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Regfile connected to the rf_* ports. Reads are registered.
   logic [31:0] rf_mem [32];
   initial begin
      for (int i = 0; i < 32; i++) rf_mem[i] = '0;
      rf_read_data = '0;
   end
   always @(posedge clk) begin
      if (rf_clear) begin
         for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
      end else if (rf_write_enable) begin
         for (int b = 0; b < 4; b++)
            if (rf_write_be[b]) rf_mem[rf_write_addr][8*b +: 8] <= rf_write_data[8*b +: 8];
      end
      if (rf_read_enable) rf_read_data <= rf_mem[rf_read_addr];
   end

   // Reference model state.
   //   m_phase: 0 = arbitrating, 1 = flushing, 2 = settling
   int          m_phase;
   int          m_ptr;
   logic [1:0]  m_rv;
   logic        m_rd;
   logic [31:0] m_data;
   logic        m_lw_v;
   logic [4:0]  m_lw_a;
   logic [31:0] ref_mem [32];

   int          n_vec;
   int          n_err;
   logic [1:0]  last_gnt;
   logic [1:0]  last_rv;
   logic [31:0] last_rdata;
   logic        last_rfclr;
   logic        last_fack;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] mask);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++)
         if (mask[b]) r[8*b +: 8] = new_v[8*b +: 8];
      return r;
   endfunction

   // Run one clock cycle. Drive the inputs, check all outputs against the
   // model at the negative edge, then advance the model past the rising edge.
   task automatic cyc(input logic [1:0] rq, input logic [1:0] we,
                      input logic [4:0] a0, input logic [4:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic [3:0] b0, input logic [3:0] b1,
                      input logic fl, input logic cl);
      logic [1:0]  elig;
      logic [1:0]  eg;
      int          w;
      logic        wwen;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [3:0]  wb;
      logic [31:0] rdv;
      req = rq; wen = we; addr = {a1, a0}; wdata = {d1, d0}; be = {b1, b0};
      flush_req = fl; clear = cl;
      #4;
      elig = rq;
`ifdef HWPE_CTRL_REGFILE_ARB_RAW_STALL_EN
      for (int i = 0; i < 2; i++)
         if (!we[i] && m_lw_v && ((i == 1 ? a1 : a0) == m_lw_a)) elig[i] = 1'b0;
`endif
      w = -1;
      if (m_phase == 0 && !cl && !fl) begin
         if (elig[m_ptr]) w = m_ptr;
         else if (elig[1 - m_ptr]) w = 1 - m_ptr;
      end
      eg   = (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);
      wwen = (w == 1) ? we[1] : we[0];
      wa   = (w == 1) ? a1 : a0;
      wd   = (w == 1) ? d1 : d0;
      wb   = (w == 1) ? b1 : b0;

      chk("gnt", gnt, eg);
      chk("rf_read_enable", rf_read_enable, (w >= 0) && !wwen);
      chk("rf_write_enable", rf_write_enable, (w >= 0) && wwen);
      if (w >= 0 && wwen) begin
         chk("rf_write_addr", rf_write_addr, wa);
         chk("rf_write_data", rf_write_data, wd);
         chk("rf_write_be", rf_write_be, wb);
      end
      if (w >= 0 && !wwen) chk("rf_read_addr", rf_read_addr, wa);
      chk("rf_clear", rf_clear, (m_phase == 1) && !cl);
      chk("flush_ack", flush_ack, (m_phase == 2) && !cl);
      chk("r_valid", r_valid, cl ? 2'b00 : m_rv);
      if (!cl && m_rv != 2'b00) chk("r_data", r_data, m_rd ? m_data : 32'h0);

      last_gnt = gnt; last_rv = r_valid; last_rdata = r_data;
      last_rfclr = rf_clear; last_fack = flush_ack;

      rdv = ref_mem[wa];
      @(posedge clk);
      #1;
      if (cl) begin
         m_phase = 0; m_ptr = 0; m_rv = 2'b00; m_rd = 1'b0; m_lw_v = 1'b0;
      end else begin
         if (m_phase == 1) for (int i = 0; i < 32; i++) ref_mem[i] = '0;
         m_phase = (m_phase == 0) ? (fl ? 1 : 0) : ((m_phase == 1) ? 2 : 0);
         m_rv    = eg;
         m_rd    = (w >= 0) && !wwen;
         m_data  = rdv;
         m_lw_v  = (w >= 0) && wwen;
         m_lw_a  = wa;
         if (w >= 0) begin
            m_ptr = 1 - w;
            if (wwen) ref_mem[wa] = merge(ref_mem[wa], wd, wb);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      m_phase = 0; m_ptr = 0; m_rv = 2'b00; m_rd = 1'b0; m_data = '0;
      m_lw_v = 1'b0; m_lw_a = '0;
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;
      clear = 1'b1; req = '0; wen = '0; addr = '0; wdata = '0; be = '0; flush_req = 1'b0;
      @(posedge clk);
      #1;

      // Reset, followed by quiet cycles.
      cyc(2'b11, 2'b00, 1, 2, 0, 0, 0, 0, 1'b0, 1'b1);
      idle(2);

      // Both requesters read continuously: grants alternate, starting with 0.
      cyc(2'b11, 2'b00, 1, 2, 0, 0, 0, 0, 1'b0, 1'b0);
      chk("rr_first", last_gnt, 2'b01);
      cyc(2'b11, 2'b00, 1, 2, 0, 0, 0, 0, 1'b0, 1'b0);
      chk("rr_second", last_gnt, 2'b10);
      for (int k = 0; k < 4; k++) cyc(2'b11, 2'b00, 1, 2, 0, 0, 0, 0, 1'b0, 1'b0);
      idle(1);

      // Write followed by read-back.
      cyc(2'b01, 2'b01, 3, 0, 32'hDEADBEEF, 0, 4'hF, 0, 1'b0, 1'b0);
      cyc(2'b01, 2'b00, 3, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      idle(1);
      chk("readback_3", last_rdata, 32'hDEADBEEF);

      // Partial byte-enable write.
      cyc(2'b01, 2'b01, 5, 0, 32'h12345678, 0, 4'hF, 0, 1'b0, 1'b0);
      cyc(2'b01, 2'b01, 5, 0, 32'hFFFFFFFF, 0, 4'h3, 0, 1'b0, 1'b0);
      cyc(2'b01, 2'b00, 5, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      idle(1);
      chk("partial_be_5", last_rdata, 32'h1234FFFF);

      // Flush while both requesters are requesting.
      cyc(2'b11, 2'b00, 3, 5, 0, 0, 0, 0, 1'b1, 1'b0);
      chk("flush_nogrant0", last_gnt, 2'b00);
      cyc(2'b11, 2'b00, 3, 5, 0, 0, 0, 0, 1'b0, 1'b0);
      chk("flush_rfclear", last_rfclr, 1'b1);
      cyc(2'b11, 2'b00, 3, 5, 0, 0, 0, 0, 1'b0, 1'b0);
      chk("flush_ack_settle", last_fack, 1'b1);
      chk("flush_nogrant2", last_gnt, 2'b00);
      cyc(2'b01, 2'b00, 3, 5, 0, 0, 0, 0, 1'b0, 1'b0);
      idle(1);
      chk("post_flush_read", last_rdata, 32'h0);

      // Flush held high through SETTLE starts another flush.
      for (int k = 0; k < 5; k++) cyc(2'b11, 2'b00, 1, 2, 0, 0, 0, 0, 1'b1, 1'b0);
      idle(3);

`ifdef HWPE_CTRL_REGFILE_ARB_RAW_STALL_EN
      // A read after a write to the same address is stalled for one cycle.
      cyc(2'b10, 2'b10, 0, 7, 0, 32'hCAFEF00D, 0, 4'hF, 1'b0, 1'b0);
      cyc(2'b01, 2'b00, 7, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      chk("raw_stall", last_gnt, 2'b00);
      cyc(2'b01, 2'b00, 7, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      chk("raw_grant", last_gnt, 2'b01);
      idle(1);
      chk("raw_data", last_rdata, 32'hCAFEF00D);
`endif

      // Reset right after a read grant: the response is dropped and the
      // round-robin pointer returns to requester 0.
      cyc(2'b01, 2'b00, 3, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      cyc(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
      chk("clear_drop_rvalid", last_rv, 2'b00);
      cyc(2'b11, 2'b00, 1, 2, 0, 0, 0, 0, 1'b0, 1'b0);
      chk("clear_ptr0", last_gnt, 2'b01);
      idle(1);

      // Randomized traffic.
      for (int k = 0; k < 400; k++) begin
         cyc(2'($urandom), 2'($urandom),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             $urandom, $urandom, 4'($urandom), 4'($urandom),
             ($urandom_range(0, 15) == 0), ($urandom_range(0, 39) == 0));
      end
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
